// File: rtl/lfsr_timer_ctrl.sv
// lfsr_timer_ctrl: LFSR period calibration and periodic/one-shot tick timer.
// Optional sticky irq output is enabled by defining LFSR_TIMER_IRQ_EN.
module lfsr_timer_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_wr,
    input  logic [W-1:0] cfg_period,
    input  logic         cfg_oneshot,
    input  logic         start,
    input  logic         stop,
    input  logic         inc,
    output logic         busy,
    output logic         ready,
    output logic         running,
    output logic         tick,
    output logic         cfg_err,
    output logic [W-1:0] count
`ifdef LFSR_TIMER_IRQ_EN
   ,input  logic         irq_clr,
    output logic         irq
`endif
);

    if (W < 4 || W > 8) begin : g_bad_w
        $error("lfsr_timer_ctrl: W must be in 4..8");
    end

    typedef enum logic [1:0] {
        IDLE,
        CAL,
        RUN
    } state_t;

    state_t       state;
    logic [W-1:0] term;
    logic [W-1:0] steps;
    logic         oneshot;
    logic [W-1:0] cnt_nxt;
    logic         hit;

    function automatic logic [W-1:0] nxt(input logic [W-1:0] q);
        logic [7:0] e;
        logic       fb;
        e = 8'(q);
        case (W)
            4:       fb = ~(e[3] ^ e[2]);
            5:       fb = ~(e[4] ^ e[2]);
            6:       fb = ~(e[5] ^ e[4]);
            7:       fb = ~(e[6] ^ e[5]);
            default: fb = ~(e[7] ^ e[5] ^ e[4] ^ e[3]);
        endcase
        return {q[W-2:0], fb};
    endfunction

    assign cnt_nxt = nxt(count);
    assign hit     = inc && (cnt_nxt == term);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ready   <= 1'b0;
            running <= 1'b0;
            tick    <= 1'b0;
            cfg_err <= 1'b0;
            count   <= '0;
            term    <= '0;
            steps   <= '0;
            oneshot <= 1'b0;
        end else begin
            tick    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (stop) begin
                        // stop in IDLE does nothing and also masks start
                    end else if (start) begin
                        if (ready) begin
                            count   <= '0;
                            running <= 1'b1;
                            state   <= RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end else if (cfg_wr) begin
                        if (cfg_period != '0) begin
                            state   <= CAL;
                            busy    <= 1'b1;
                            ready   <= 1'b0;
                            term    <= '0;
                            steps   <= cfg_period;
                            oneshot <= cfg_oneshot;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                CAL: begin
                    term  <= nxt(term);
                    steps <= steps - W'(1);
                    if (cfg_wr || start)
                        cfg_err <= 1'b1;
                    if (steps == W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (cfg_wr)
                        cfg_err <= 1'b1;
                    if (stop) begin
                        // an expiry coinciding with stop still ticks
                        tick    <= hit;
                        count   <= '0;
                        running <= 1'b0;
                        state   <= IDLE;
                    end else if (start) begin
                        count <= '0;
                    end else if (inc) begin
                        if (hit) begin
                            count <= '0;
                            tick  <= 1'b1;
                            if (oneshot) begin
                                running <= 1'b0;
                                state   <= IDLE;
                            end
                        end else begin
                            count <= cnt_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LFSR_TIMER_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst)
            irq <= 1'b0;
        else if (tick)
            irq <= 1'b1;
        else if (irq_clr)
            irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_lfsr_timer_ctrl.sv
// tb_lfsr_timer_ctrl: directed checks of lfsr_timer_ctrl at W=4.
// Covers irq behaviour too when LFSR_TIMER_IRQ_EN is defined.
module tb_lfsr_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_wr;
    logic [3:0] cfg_period;
    logic       cfg_oneshot;
    logic       start;
    logic       stop;
    logic       inc;
    logic       busy;
    logic       ready;
    logic       running;
    logic       tick;
    logic       cfg_err;
    logic [3:0] count;
`ifdef LFSR_TIMER_IRQ_EN
    logic       irq_clr;
    logic       irq;
`endif

    int checks   = 0;
    int failures = 0;

    logic [3:0] seq4 [15] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB,
                              4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4,
                              4'h8};

    always #5 clk = ~clk;

    lfsr_timer_ctrl #(.W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_wr     (cfg_wr),
        .cfg_period (cfg_period),
        .cfg_oneshot(cfg_oneshot),
        .start      (start),
        .stop       (stop),
        .inc        (inc),
        .busy       (busy),
        .ready      (ready),
        .running    (running),
        .tick       (tick),
        .cfg_err    (cfg_err),
        .count      (count)
`ifdef LFSR_TIMER_IRQ_EN
       ,.irq_clr    (irq_clr),
        .irq        (irq)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Writes a period and returns how many cycles busy stayed high.
    task automatic configure(input logic [3:0] p, input logic os,
                             output int n);
        cfg_wr      = 1'b1;
        cfg_period  = p;
        cfg_oneshot = os;
        step();
        cfg_wr = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({busy, ready, running, tick, cfg_err, count} !== 9'd0) begin
            failures++;
            $display("FAIL reset outs got=%b exp=0",
                     {busy, ready, running, tick, cfg_err, count});
        end
    endtask

    task automatic test_start_unconfigured();
        do_start();
        checks++;
        if ({cfg_err, running} !== 2'b10) begin
            failures++;
            $display("FAIL start_noready got=%b exp=10", {cfg_err, running});
        end
        step();
        checks++;
        if ({cfg_err, running} !== 2'b00) begin
            failures++;
            $display("FAIL start_noready_after got=%b exp=00",
                     {cfg_err, running});
        end
    endtask

    task automatic test_periodic5();
        int n;
        logic [3:0] ec [10] = '{1, 3, 7, 4'hE, 0, 1, 3, 7, 4'hE, 0};
        configure(4'd5, 1'b0, n);
        checks++;
        if (n != 5 || ready !== 1'b1) begin
            failures++;
            $display("FAIL p5_cal busy_cycles=%0d ready=%b exp=5,1", n, ready);
        end
        inc = 1'b1;
        do_start();
        checks++;
        if ({running, count} !== 5'b1_0000) begin
            failures++;
            $display("FAIL p5_start got=%b exp=10000", {running, count});
        end
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if ({tick, count} !== {(k % 5 == 4), ec[k]}) begin
                failures++;
                $display("FAIL p5_seq%0d got=%b exp=%b", k, {tick, count},
                         {(k % 5 == 4), ec[k]});
            end
        end
        inc  = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({running, tick, count} !== 6'd0) begin
            failures++;
            $display("FAIL p5_stop got=%b exp=0", {running, tick, count});
        end
    endtask

    task automatic test_p1();
        int n;
        configure(4'd1, 1'b0, n);
        checks++;
        if (n != 1 || ready !== 1'b1) begin
            failures++;
            $display("FAIL p1_cal busy_cycles=%0d ready=%b exp=1,1", n, ready);
        end
        do_start();
        inc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({tick, count} !== 5'b1_0000) begin
                failures++;
                $display("FAIL p1_tick%0d got=%b exp=10000", k, {tick, count});
            end
        end
        inc  = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_p15();
        int n;
        int bad = 0;
        configure(4'd15, 1'b0, n);
        checks++;
        if (n != 15) begin
            failures++;
            $display("FAIL p15_cal busy_cycles=%0d exp=15", n);
        end
        do_start();
        inc = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            if ({tick, count} !== {(k == 15), seq4[k % 15]}) begin
                bad++;
                $display("FAIL p15_state%0d got=%b exp=%b", k, {tick, count},
                         {(k == 15), seq4[k % 15]});
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL p15_walk got=%0d bad states exp=0", bad);
        end
        inc  = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_p0();
        cfg_wr     = 1'b1;
        cfg_period = 4'd0;
        step();
        cfg_wr = 1'b0;
        checks++;
        if ({cfg_err, ready, busy} !== 3'b110) begin
            failures++;
            $display("FAIL p0_reject got=%b exp=110", {cfg_err, ready, busy});
        end
        step();
        checks++;
        if ({cfg_err, ready} !== 2'b01) begin
            failures++;
            $display("FAIL p0_after got=%b exp=01", {cfg_err, ready});
        end
    endtask

    task automatic test_oneshot3();
        int n;
        logic       pat [5] = '{1, 0, 1, 0, 1};
        logic [5:0] ex  [5] = '{6'b10_0001, 6'b10_0001, 6'b10_0011,
                               6'b10_0011, 6'b01_0000};
        configure(4'd3, 1'b1, n);
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL os3_cal busy_cycles=%0d exp=3", n);
        end
        do_start();
        for (int k = 0; k < 5; k++) begin
            inc = pat[k];
            step();
            checks++;
            if ({running, tick, count} !== ex[k]) begin
                failures++;
                $display("FAIL os3_step%0d got=%b exp=%b", k,
                         {running, tick, count}, ex[k]);
            end
        end
        inc = 1'b1;
        step();
        inc = 1'b0;
        checks++;
        if ({ready, running, tick, count} !== 7'b100_0000) begin
            failures++;
            $display("FAIL os3_done got=%b exp=1000000",
                     {ready, running, tick, count});
        end
    endtask

    task automatic test_run_errors();
        int n;
        logic [3:0] ec [5] = '{1, 3, 7, 4'hE, 0};
        configure(4'd5, 1'b0, n);
        do_start();
        inc = 1'b1;
        repeat (3) step();
        inc        = 1'b0;
        cfg_wr     = 1'b1;
        cfg_period = 4'd2;
        step();
        cfg_wr = 1'b0;
        checks++;
        if ({cfg_err, running, busy, count} !== 7'b110_0111) begin
            failures++;
            $display("FAIL run_cfgwr got=%b exp=1100111",
                     {cfg_err, running, busy, count});
        end
        do_start();
        checks++;
        if ({running, count} !== 5'b1_0000) begin
            failures++;
            $display("FAIL run_restart got=%b exp=10000", {running, count});
        end
        inc = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if ({tick, count} !== {(k == 4), ec[k]}) begin
                failures++;
                $display("FAIL run_period%0d got=%b exp=%b", k, {tick, count},
                         {(k == 4), ec[k]});
            end
        end
        inc = 1'b0;
    endtask

    task automatic test_stop_start();
        inc = 1'b1;
        repeat (2) step();
        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        inc   = 1'b0;
        checks++;
        if ({running, tick, count} !== 6'd0) begin
            failures++;
            $display("FAIL stop_start got=%b exp=0", {running, tick, count});
        end
        step();
        checks++;
        if ({running, count} !== 5'd0) begin
            failures++;
            $display("FAIL stop_start_hold got=%b exp=0", {running, count});
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({ready, running, cfg_err} !== 3'b100) begin
            failures++;
            $display("FAIL stop_idle got=%b exp=100", {ready, running, cfg_err});
        end
    endtask

    task automatic test_expiry_stop();
        do_start();
        inc = 1'b1;
        repeat (4) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        inc  = 1'b0;
        checks++;
        if ({running, tick, count} !== 6'b01_0000) begin
            failures++;
            $display("FAIL expiry_stop got=%b exp=010000",
                     {running, tick, count});
        end
    endtask

    task automatic test_reset_cal_run();
        int n;
        cfg_wr     = 1'b1;
        cfg_period = 4'd15;
        step();
        cfg_wr = 1'b0;
        step();
        cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
        checks++;
        if ({cfg_err, busy} !== 2'b11) begin
            failures++;
            $display("FAIL cal_cfgwr got=%b exp=11", {cfg_err, busy});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy, ready, running, tick, cfg_err, count} !== 9'd0) begin
            failures++;
            $display("FAIL rst_cal got=%b exp=0",
                     {busy, ready, running, tick, cfg_err, count});
        end
        configure(4'd3, 1'b0, n);
        do_start();
        inc = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        inc = 1'b0;
        checks++;
        if ({busy, ready, running, tick, cfg_err, count} !== 9'd0) begin
            failures++;
            $display("FAIL rst_run got=%b exp=0",
                     {busy, ready, running, tick, cfg_err, count});
        end
    endtask

`ifdef LFSR_TIMER_IRQ_EN
    task automatic test_irq();
        int n;
        configure(4'd1, 1'b0, n);
        do_start();
        inc = 1'b1;
        step();
        inc = 1'b0;
        step();
        step();
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_latch got=%b exp=1", irq);
        end
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_clr got=%b exp=0", irq);
        end
        inc = 1'b1;
        step();
        inc     = 1'b0;
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_set_wins got=%b exp=1", irq);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask
`endif

    initial begin
        rst         = 1'b1;
        cfg_wr      = 1'b0;
        cfg_period  = 4'd0;
        cfg_oneshot = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        inc         = 1'b0;
`ifdef LFSR_TIMER_IRQ_EN
        irq_clr     = 1'b0;
`endif
        test_reset();
        test_start_unconfigured();
        test_periodic5();
        test_p1();
        test_p15();
        test_p0();
        test_oneshot3();
        test_run_errors();
        test_stop_start();
        test_expiry_stop();
        test_reset_cal_run();
`ifdef LFSR_TIMER_IRQ_EN
        test_irq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
